// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths, request record and FSM states for the data-RAM arbiter
package dmem_pkg;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int NREQ = 2;
    localparam int BEW  = DW / 8;
    typedef struct packed {
        logic           we;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  wdata;
        logic [BEW-1:0] be;
    } dmem_req_t;
    typedef enum logic {IDLE, ACCESS} arb_state_e;
endpackage

// File: rtl/dmem_byte_merge.sv
// dmem_byte_merge: per-byte select of new data over the stored word
//   old_i  : word currently in RAM
//   new_i  : lane-aligned store data
//   be_i   : byte enables, 1 = take the new byte
//   merged_o : word to write back
module dmem_byte_merge
    import dmem_pkg::*;
(
    input  logic [DW-1:0]  old_i,
    input  logic [DW-1:0]  new_i,
    input  logic [BEW-1:0] be_i,
    output logic [DW-1:0]  merged_o
);
    for (genvar i = 0; i < BEW; i++) begin : g_lane
        assign merged_o[8*i +: 8] = be_i[i] ? new_i[8*i +: 8] : old_i[8*i +: 8];
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of a single-port word RAM
//   req_*  : per-port valid/ready request channel (we, byte addr, wdata, be)
//   rsp_*  : per-port one-cycle response pulse, shared rdata and error flag
//   ram_*  : RAM write enable, word index, merged write data, combinational read data
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned RAM_NUM = 10_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ-1:0]           req_we,
    input  logic [NREQ-1:0][AW-1:0]   req_addr,
    input  logic [NREQ-1:0][DW-1:0]   req_wdata,
    input  logic [NREQ-1:0][BEW-1:0]  req_be,
    output logic [NREQ-1:0]           rsp_valid,
    output logic [DW-1:0]             rsp_rdata,
    output logic                      rsp_err,
    output logic                      ram_wr_en,
    output logic [AW-1:0]             ram_addr,
    output logic [DW-1:0]             ram_wdata,
    input  logic [DW-1:0]             ram_rdata
);
    arb_state_e      state_q;
    dmem_req_t       req_q;
    logic            rr_q;
    logic            gnt_q;
    logic [NREQ-1:0] rsp_valid_q;
    logic            rsp_err_q;
    logic [DW-1:0]   rsp_rdata_q;
    logic [DW-1:0]   wdata_hold_q;
    logic            gnt;
    logic            in_range;
    logic [DW-1:0]   merged;

    // round-robin pointer only breaks ties; a lone requester always wins
    assign gnt       = &req_valid ? rr_q : req_valid[1];
    assign req_ready = (!rst && state_q == IDLE && |req_valid) ? (2'b01 << gnt) : '0;
    // latched request persists until the next grant, so the index holds outside ACCESS
    assign ram_addr  = {2'b00, req_q.addr[AW-1:2]};
    assign in_range  = ram_addr < RAM_NUM;
    assign ram_wr_en = state_q == ACCESS && req_q.we && in_range;
    assign ram_wdata = state_q == ACCESS ? merged : wdata_hold_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

    dmem_byte_merge u_merge (
        .old_i    (ram_rdata),
        .new_i    (req_q.wdata),
        .be_i     (req_q.be),
        .merged_o (merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            req_q        <= '0;
            rr_q         <= 1'b0;
            gnt_q        <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
            wdata_hold_q <= '0;
        end else begin
            rsp_valid_q <= '0;
            if (state_q == IDLE) begin
                if (|req_valid) begin
                    state_q <= ACCESS;
                    gnt_q   <= gnt;
                    rr_q    <= ~gnt;
                    req_q   <= '{we: req_we[gnt], addr: req_addr[gnt],
                                 wdata: req_wdata[gnt], be: req_be[gnt]};
                end
            end else begin
                state_q      <= IDLE;
                rsp_valid_q  <= 2'b01 << gnt_q;
                rsp_err_q    <= !in_range;
                rsp_rdata_q  <= in_range ? ram_rdata : '0;
                wdata_hold_q <= merged;
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed-vector bench for dmem_arbiter with a small RAM model
module tb_dmem_arbiter;
    localparam int unsigned RAM_NUM = 10_000_000;
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       req_valid = '0;
    logic [1:0]       req_we = '0;
    logic [1:0][31:0] req_addr = '0;
    logic [1:0][31:0] req_wdata = '0;
    logic [1:0][3:0]  req_be = '0;
    logic [1:0]       req_ready;
    logic [1:0]       rsp_valid;
    logic [31:0]      rsp_rdata;
    logic             rsp_err;
    logic             ram_wr_en;
    logic [31:0]      ram_addr;
    logic [31:0]      ram_wdata;
    logic [31:0]      ram_rdata;
    logic [31:0]      mem [0:63];
    int               wr_cnt = 0;
    int               n_cmp = 0;
    int               n_err = 0;
    logic             exp_rr = 1'b0;
    int               wr_snap;

    dmem_arbiter #(.RAM_NUM(RAM_NUM)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_wr_en(ram_wr_en), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    assign ram_rdata = mem[ram_addr[5:0]];
    always @(posedge clk) begin
        if (ram_wr_en) begin
            mem[ram_addr[5:0]] <= ram_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // single request from port p, starting #1 after a rising edge (its grant cycle)
    task automatic xact(input int p, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input logic exp_wr, input logic [31:0] exp_wd,
                        input logic [31:0] exp_rd, input logic exp_err);
        req_valid[p] = 1'b1;
        req_we[p]    = we;
        req_addr[p]  = addr;
        req_wdata[p] = wd;
        req_be[p]    = be;
        #1;
        chk("grant", {30'd0, req_ready}, p ? 32'd2 : 32'd1);
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
        chk("ready_in_access", {30'd0, req_ready}, 32'd0);
        chk("rsp_pulse_len", {30'd0, rsp_valid}, 32'd0);
        chk("wr_en", {31'd0, ram_wr_en}, {31'd0, exp_wr});
        chk("ram_addr", ram_addr, addr >> 2);
        if (exp_wr) chk("merge", ram_wdata, exp_wd);
        @(posedge clk); #1;
        chk("rsp_valid", {30'd0, rsp_valid}, p ? 32'd2 : 32'd1);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
        if (!we || exp_err) chk("rdata", rsp_rdata, exp_rd);
        exp_rr = (p == 0);
    endtask

    // both ports hold loads of word 4 (port 0) and word 8 (port 1) for n grants
    task automatic rr_run(input int n);
        logic g;
        req_valid = 2'b11;
        req_we    = 2'b00;
        req_addr  = {32'h20, 32'h10};
        for (int i = 0; i < n; i++) begin
            #1;
            g = exp_rr;
            chk("rr_grant", {30'd0, req_ready}, g ? 32'd2 : 32'd1);
            @(posedge clk); #1;
            chk("rr_ready_in_access", {30'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
            chk("rr_rsp_valid", {30'd0, rsp_valid}, g ? 32'd2 : 32'd1);
            chk("rr_rdata", rsp_rdata, g ? 32'hAA22CC44 : 32'hDEADBEEF);
            exp_rr = ~g;
        end
        req_valid = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        req_valid = 2'b01;
        #1;
        chk("reset_ready", {30'd0, req_ready}, 32'd0);
        chk("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("reset_rdata", rsp_rdata, 32'd0);
        chk("reset_wr_en", {31'd0, ram_wr_en}, 32'd0);
        chk("reset_ram_addr", ram_addr, 32'd0);
        chk("reset_ram_wdata", ram_wdata, 32'd0);
        req_valid = 2'b00;
        rst = 1'b0;
        @(posedge clk); #1;
        xact(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 32'hDEADBEEF, 32'h0, 1'b0);
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
        xact(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'hF, 1'b1, 32'hAABBCCDD, 32'h0, 1'b0);
        xact(1, 1'b1, 32'h22, 32'h11223344, 4'b0101, 1'b1, 32'hAA22CC44, 32'h0, 1'b0);
        xact(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h0, 32'hAA22CC44, 1'b0);
        xact(0, 1'b1, 32'h24, 32'h55667788, 4'hF, 1'b1, 32'h55667788, 32'h0, 1'b0);
        xact(0, 1'b1, 32'h24, 32'hFFFFFFFF, 4'h0, 1'b1, 32'h55667788, 32'h0, 1'b0);
        xact(1, 1'b0, 32'h24, 32'h0, 4'h0, 1'b0, 32'h0, 32'h55667788, 1'b0);
        rr_run(8);
        wr_snap = wr_cnt;
        xact(0, 1'b1, RAM_NUM * 4, 32'h12345678, 4'hF, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("oor_no_write", wr_cnt, wr_snap);
        xact(1, 1'b0, 32'hFFFFFFFC, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        xact(1, 1'b1, (RAM_NUM - 1) * 4, 32'h0BADF00D, 4'hF, 1'b1, 32'h0BADF00D, 32'h0, 1'b0);
        xact(0, 1'b0, (RAM_NUM - 1) * 4, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0BADF00D, 1'b0);
        // store from port 0 interrupted by reset in its ACCESS cycle
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h10;
        req_wdata[0] = 32'h12345678;
        req_be[0]    = 4'hF;
        #1;
        chk("rst_grant", {30'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        chk("rst_access_wr_en", {31'd0, ram_wr_en}, 32'd1);
        wr_snap = wr_cnt;
        rst = 1'b1;
        #1;
        chk("rst_wr_en", {31'd0, ram_wr_en}, 32'd0);
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        @(posedge clk); #1;
        chk("rst_no_rsp", {30'd0, rsp_valid}, 32'd0);
        chk("rst_no_write", wr_cnt, wr_snap);
        rst = 1'b0;
        exp_rr = 1'b0;
        @(posedge clk); #1;
        chk("rst_no_rsp_after", {30'd0, rsp_valid}, 32'd0);
        xact(1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
        exp_rr = 1'b0;
        rr_run(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
